// File: rtl/cpu_async_pkg.sv
// Shared dual-rail constants, phase-FSM states and token packing for the async CPU phase logic.
// ST_ERROR exists only when CPU_PHSEQ_WATCHDOG_EN is defined.
package cpu_async_pkg;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_ZERO = 2'b01;
  localparam logic [1:0] DR_ONE  = 2'b10;

  // Widest phase vector dr_pack can build; callers cast down to 2*NUM_PH bits.
  localparam int unsigned DR_MAX_PH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_WAIT_HI,
    ST_RTZ,
    ST_WAIT_LO
`ifdef CPU_PHSEQ_WATCHDOG_EN
    , ST_ERROR
`endif
  } ph_state_e;

  function automatic logic [2*DR_MAX_PH-1:0] dr_pack(input int unsigned idx, input logic val);
    logic [2*DR_MAX_PH-1:0] v;
    v = {{(2*DR_MAX_PH-2){1'b0}}, (val ? DR_ONE : DR_ZERO)};
    return v << (2 * idx);
  endfunction

endpackage

// File: rtl/ack_synchronizer.sv
// Multi-flop synchroniser bringing the datapath completion acknowledge into the clk domain.
module ack_synchronizer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ack_i,
  output logic ack_s_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], ack_i};
  end

  assign ack_s_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Issues NUM_PH dual-rail phase tokens per round, each with a four-phase RTZ handshake on ack.
// Optional watchdog and sticky timeout_err are compiled in with CPU_PHSEQ_WATCHDOG_EN.
module cpu_phase_sequencer
  import cpu_async_pkg::*;
#(
  parameter int unsigned NUM_PH      = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic [NUM_PH-1:0]         ph_mask,
  input  logic                      ack,
  output logic [2*NUM_PH-1:0]       ph,
  output logic [$clog2(NUM_PH)-1:0] cur_ph,
  output logic                      busy,
  output logic                      round_done
`ifdef CPU_PHSEQ_WATCHDOG_EN
  ,
  output logic                      timeout_err
`endif
);

  localparam int unsigned   PW      = $clog2(NUM_PH);
  localparam int unsigned   PHW     = 2 * NUM_PH;
  localparam logic [PW-1:0] LAST_PH = PW'(NUM_PH - 1);

  ph_state_e         state_q, state_d;
  logic [NUM_PH-1:0] mask_q,  mask_d;
  logic [PW-1:0]     cur_q,   cur_d;
  logic [PHW-1:0]    ph_q,    ph_d;
  logic              done_q,  done_d;
  logic              ack_s;

  ack_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk    (clk),
    .rst    (rst),
    .ack_i  (ack),
    .ack_s_o(ack_s)
  );

`ifdef CPU_PHSEQ_WATCHDOG_EN
  // Expiry fires on the cycle the counter would step onto all-ones.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 err_q, err_d;
  logic                 waiting;
  assign waiting = (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);
`else
  localparam int unsigned timeout_w_unused = TIMEOUT_W;
`endif

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cur_d   = cur_q;
    ph_d    = '0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run && !ack_s) begin
          mask_d  = ph_mask;
          cur_d   = '0;
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        ph_d    = PHW'(dr_pack(32'(cur_q), mask_q[cur_q]));
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (ack_s) state_d = ST_RTZ;
        else       ph_d    = ph_q;
      end
      ST_RTZ: state_d = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!ack_s) begin
          if (cur_q != LAST_PH) begin
            cur_d   = cur_q + PW'(1);
            state_d = ST_ASSERT;
          end else begin
            done_d = 1'b1;
            if (run) begin
              mask_d  = ph_mask;
              cur_d   = '0;
              state_d = ST_ASSERT;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
`ifdef CPU_PHSEQ_WATCHDOG_EN
      ST_ERROR: state_d = ST_ERROR;
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef CPU_PHSEQ_WATCHDOG_EN
    err_d = err_q;
    wd_d  = (waiting && state_d == state_q) ? wd_q + TIMEOUT_W'(1) : '0;
    if (waiting && state_d == state_q && wd_q == WD_LAST) begin
      state_d = ST_ERROR;
      ph_d    = '0;
      err_d   = 1'b1;
      wd_d    = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      cur_q   <= '0;
      ph_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cur_q   <= cur_d;
      ph_q    <= ph_d;
      done_q  <= done_d;
    end
  end

`ifdef CPU_PHSEQ_WATCHDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign timeout_err = err_q;
`endif

  assign ph         = ph_q;
  assign cur_ph     = cur_q;
  assign busy       = (state_q != ST_IDLE);
  assign round_done = done_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Randomised bench for cpu_phase_sequencer: a datapath ack responder with random reaction delays,
// checked against a round/phase level model of token order, values and handshake latencies.
module tb_cpu_phase_sequencer;

  localparam int unsigned NP = 3;
  localparam int unsigned SS = 2;
  localparam int unsigned TW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            run;
  logic            ack;
  logic [NP-1:0]   ph_mask;
  logic [2*NP-1:0] ph;
  logic [1:0]      cur_ph;
  logic            busy;
  logic            round_done;
`ifdef CPU_PHSEQ_WATCHDOG_EN
  logic            timeout_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  cpu_phase_sequencer #(
    .NUM_PH     (NP),
    .SYNC_STAGES(SS),
    .TIMEOUT_W  (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .ph_mask    (ph_mask),
    .ack        (ack),
    .ph         (ph),
    .cur_ph     (cur_ph),
    .busy       (busy),
    .round_done (round_done)
`ifdef CPU_PHSEQ_WATCHDOG_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    int unsigned exp_idx, wait_n, freeze_n, rounds_exp;
    int k, v, nz, bad;
    int run_cyc, ack_rise, ack_fall, last_fall, last_evt;
    logic [NP-1:0] round_mask;
    bit tok_prev, first, frozen, idle_exp, rst_phase, rst_done, stop;
    int resp;  // 0 wait, 1 raise pending, 2 drop pending

    rst = 1'b1; run = 1'b0; ack = 1'b0; ph_mask = '0;
    exp_idx = 0; wait_n = 0; freeze_n = 0; rounds_exp = 0;
    tok_prev = 0; idle_exp = 0; rst_phase = 0; rst_done = 0; stop = 0; resp = 0;
    ack_rise = 0; ack_fall = 0; last_fall = -100;
    repeat (2) @(negedge clk);
    check_eq("rst_ph", ph, 0);
    check_eq("rst_cur_ph", cur_ph, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_round_done", round_done, 0);
`ifdef CPU_PHSEQ_WATCHDOG_EN
    check_eq("rst_timeout_err", timeout_err, 0);
`endif

    rst = 1'b0; run = 1'b1; ph_mask = 3'b111; round_mask = 3'b111;
    run_cyc = cyc; first = 1; frozen = 1; last_evt = cyc;

    while (!stop) begin
      @(negedge clk);
      if (rst_phase) begin
        check_eq("rst_hold_ph", ph, 0);
        check_eq("rst_hold_cur_ph", cur_ph, 0);
        check_eq("rst_hold_busy", busy, 0);
        rst = 1'b0; run = 1'b1; ph_mask = NP'($urandom); round_mask = ph_mask;
        run_cyc = cyc; first = 1; frozen = 1; exp_idx = 0; resp = 0; tok_prev = 0;
        last_fall = -100; idle_exp = 0; last_evt = cyc; rst_phase = 0; rst_done = 1;
        continue;
      end

      nz = 0; bad = 0; k = -1; v = 0;
      for (int p = 0; p < int'(NP); p++) begin
        if (ph[2*p +: 2] == 2'b11) bad = 1;
        if (ph[2*p +: 2] != 2'b00) begin nz++; k = p; v = int'(ph[2*p +: 2]); end
      end
      if (nz > 1) bad = 1;
      check_eq("pair_legal", bad, 0);
      check_eq("round_done", round_done, (cyc == last_fall + 3) ? 1 : 0);
      if (idle_exp && cyc >= last_fall + 4) begin
        check_eq("idle_busy", busy, 0);
        check_eq("idle_ph", ph, 0);
      end

      if (nz != 0 && !tok_prev) begin
        last_evt = cyc;
        check_eq("tok_idx", k, exp_idx);
        check_eq("tok_val", v, round_mask[exp_idx] ? 2 : 1);
        check_eq("tok_cur_ph", cur_ph, exp_idx);
        check_eq("tok_busy", busy, 1);
        if (first) check_eq("lat_start", cyc - run_cyc, 2);
        else       check_eq("lat_next", cyc - ack_fall, SS + 2);
        first = 0;
        if (exp_idx == 0) frozen = 0;
        if (exp_idx == NP - 1) begin
          frozen = 1;
          ph_mask = (freeze_n == 0) ? 3'b010 : NP'($urandom);
          freeze_n++;
        end
        if (exp_idx == 1 && run && freeze_n > 1 && $urandom_range(0, 3) == 0) run = 1'b0;
        if (!rst_done && rounds_exp >= 3 && exp_idx == 1 && v == 2) begin
          #2 rst = 1'b1;
          #1;
          check_eq("async_rst_ph", ph, 0);
          check_eq("async_rst_cur_ph", cur_ph, 0);
          check_eq("async_rst_busy", busy, 0);
          check_eq("async_rst_round_done", round_done, 0);
          rst_phase = 1;
          continue;
        end
        resp = 1; wait_n = $urandom_range(0, 3);
      end
      if (nz == 0 && tok_prev) begin
        last_evt = cyc;
        check_eq("lat_rtz", cyc - ack_rise, SS + 1);
        resp = 2; wait_n = $urandom_range(0, 3);
      end
      tok_prev = (nz != 0);

      if (resp == 1) begin
        if (wait_n == 0) begin ack = 1'b1; ack_rise = cyc; resp = 0; end
        else wait_n--;
      end else if (resp == 2) begin
        if (wait_n == 0) begin
          ack = 1'b0; ack_fall = cyc; resp = 0;
          if (exp_idx == NP - 1) begin
            last_fall = cyc; rounds_exp++;
            if (run) round_mask = ph_mask;
            else     idle_exp = 1;
          end
          exp_idx = (exp_idx + 1) % NP;
        end else wait_n--;
      end

      if (idle_exp && cyc >= last_fall + 4 && $urandom_range(0, 3) == 0) begin
        ph_mask = NP'($urandom); round_mask = ph_mask; run = 1'b1;
        run_cyc = cyc; first = 1; frozen = 1; idle_exp = 0; last_evt = cyc;
      end
      if (!frozen && $urandom_range(0, 1) == 1) ph_mask = NP'($urandom);

      if (!idle_exp && cyc - last_evt > 40) begin
        check_eq("stall", cyc - last_evt, 0);
        stop = 1;
      end
      if (cyc > 20000) begin
        check_eq("cycle_budget", cyc, 20000);
        stop = 1;
      end
      if (rounds_exp >= 30 && rst_done) stop = 1;
    end
    check_eq("rst_test_reached", rst_done, 1);

    // No acknowledge at all: token must stay, or the watchdog must trip.
    rst = 1'b1; ack = 1'b0; run = 1'b0;
    @(negedge clk);
    rst = 1'b0; run = 1'b1; ph_mask = 3'b111; run_cyc = cyc;
    repeat (2) @(negedge clk);
    check_eq("noack_tok", ph, 6'b000010);
`ifdef CPU_PHSEQ_WATCHDOG_EN
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      check_eq("wd_pre_err", timeout_err, 0);
      check_eq("wd_pre_ph", ph, 6'b000010);
    end
    @(negedge clk);
    check_eq("wd_err", timeout_err, 1);
    check_eq("wd_ph", ph, 0);
    ack = 1'b1;
    repeat (6) @(negedge clk);
    ack = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("wd_sticky", timeout_err, 1);
    check_eq("wd_stuck_ph", ph, 0);
    check_eq("wd_stuck_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_eq("wd_rst_clear", timeout_err, 0);
`else
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      check_eq("noack_hold_ph", ph, 6'b000010);
      check_eq("noack_hold_busy", busy, 1);
    end
    rst = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
